// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_pkg
//  Description : Shared constants for the MAC control sequencer. These are the
//                sequencer state encodings, the MODE encodings, and a helper
//                that derives the channel-select width.
//  Revision    : 1.0  initial release
// ============================================================================
package mac_pkg;

    // Sequencer state encoding (3 bits, legacy-compatible values)
    localparam logic [2:0] ST_IDLE   = 3'b000;
    localparam logic [2:0] ST_CLEAR  = 3'b001;
    localparam logic [2:0] ST_RUN    = 3'b010;
    localparam logic [2:0] ST_LOAD   = 3'b011;
    localparam logic [2:0] ST_DONE_S = 3'b100;

    // Command MODE encoding
    localparam logic MODE_CLEAR = 1'b0;   // clear accumulator before the run
    localparam logic MODE_ACCUM = 1'b1;   // accumulate onto existing contents

    // Width of a channel-select field for CH channels (never below 1 bit)
    function automatic int ch_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage : mac_pkg
`default_nettype wire

// File: rtl/mac_op_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mac_op_counter
//  Description : Operation counter for the MAC sequencer. It counts accepted
//                beats and flags the beat whose count equals the terminal
//                value minus one, which is the last beat of the command.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk_i    in   clock
//    rst_i    in   asynchronous active-high reset
//    clear_i  in   synchronous clear of the count
//    inc_i    in   increment the count this cycle
//    term_i   in   terminal value (command length, non-zero while counting)
//    count_o  out  current count
//    last_o   out  current count is the final beat (count == term-1)
// ============================================================================
module mac_op_counter #(
    parameter int LEN_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             inc_i,
    input  logic [LEN_W-1:0] term_i,
    output logic [LEN_W-1:0] count_o,
    output logic             last_o
);

    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Comparing against term-1 means the count never has to reach term. So a
    // maximum-length command (2^LEN_W-1) completes without wrapping.
    assign last_o  = (count_q == (term_i - LEN_W'(1)));
    assign count_o = count_q;

endmodule : mac_op_counter
`default_nettype wire

// File: rtl/mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mac_sequencer
//  Description : Control sequencer for the MAC datapath. It accepts a command
//                (length, channel, mode) through a start pulse. It then drives
//                clear / enable / load strobes to the datapath and signals
//                completion with a one-cycle done pulse.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk_i       in   clock
//    rst_i       in   asynchronous active-high reset
//    start_i     in   command request, sampled only in IDLE
//    len_i       in   number of MAC operations (latched on accepted start)
//    ch_sel_i    in   target accumulator channel (latched, saturated to CH-1)
//    mode_i      in   0 = clear first, 1 = accumulate onto existing value
//    abort_i     in   cancel the running command (CLEAR / RUN only)
//    in_valid_i  in   operand pair present on the datapath inputs
//    in_ready_o  out  operands are consumed this cycle (RUN)
//    clr_o       out  clear selected accumulator
//    en_o        out  one multiply-accumulate into the selected accumulator
//    acc_sel_o   out  accumulator channel select
//    out_load_o  out  latch selected accumulator into the output register
//    busy_o      out  command in progress (CLEAR, RUN, LOAD)
//    done_o      out  one-cycle completion pulse
// ============================================================================
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int LEN_W = 4,
    parameter int CH    = 2,
    parameter int CH_W  = ch_width(CH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [CH_W-1:0]  ch_sel_i,
    input  logic             mode_i,
    input  logic             abort_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             clr_o,
    output logic             en_o,
    output logic [CH_W-1:0]  acc_sel_o,
    output logic             out_load_o,
    output logic             busy_o,
    output logic             done_o
);

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_d;
    logic [CH_W-1:0]  ch_q;
    logic [CH_W-1:0]  ch_d;

    logic             w_accept;
    logic             w_beat;
    logic             w_last;
    logic [CH_W-1:0]  w_ch_sat;
    logic [LEN_W-1:0] w_unused_count;

    // Saturation is only needed when the select field can encode values that
    // have no channel behind them.
    if ((1 << CH_W) > CH) begin : g_sat
        localparam logic [CH_W-1:0] C_CH_MAX = CH_W'(CH - 1);
        assign w_ch_sat = (ch_sel_i > C_CH_MAX) ? C_CH_MAX : ch_sel_i;
    end else begin : g_nosat
        assign w_ch_sat = ch_sel_i;
    end

    assign w_accept = (state_q == ST_IDLE) && start_i;
    // A beat is consumed only when the command is not being aborted.
    assign w_beat   = (state_q == ST_RUN) && in_valid_i && !abort_i;

    mac_op_counter #(
        .LEN_W (LEN_W)
    ) u_op_counter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (w_accept),
        .inc_i   (w_beat),
        .term_i  (len_q),
        .count_o (w_unused_count),
        .last_o  (w_last)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        ch_d    = ch_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    len_d = len_i;
                    ch_d  = w_ch_sat;
                    if (len_i == '0) begin
                        state_d = ST_DONE_S;
                    end else if (mode_i == MODE_ACCUM) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: begin
                state_d = abort_i ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                // Abort takes precedence over completing on the last beat
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (in_valid_i && w_last) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_DONE_S;
            end
            ST_DONE_S: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ch_q    <= ch_d;
        end
    end

    // All strobes decode directly from the state register. This lets reset
    // zero them immediately, without waiting for a clock edge.
    assign in_ready_o = (state_q == ST_RUN);
    assign clr_o      = (state_q == ST_CLEAR);
    assign en_o       = w_beat;
    assign out_load_o = (state_q == ST_LOAD);
    assign done_o     = (state_q == ST_DONE_S);
    assign busy_o     = (state_q == ST_CLEAR) || (state_q == ST_RUN) ||
                        (state_q == ST_LOAD);
    assign acc_sel_o  = ch_q;

endmodule : mac_sequencer
`default_nettype wire

// File: doc/mac_sequencer.md
# mac_sequencer

Parametrised control sequencer for the MAC unit datapath. It replaces the fixed 3-bit, 2-input controller with a start/done handshake and a programmable vector length. It supports multiple accumulator channels and an accumulate-onto-existing mode. It sits between the command source and the MAC datapath, driving the accumulator clear, MAC enable, channel select and result-load strobes.

## Interface
- LEN_W, 4, width of the vector-length field and operation counter (max length 2^LEN_W−1)
- CH, 2, number of accumulator channels (≥1)
- CH_W, max(1,clog2(CH)), width of the channel-select field (derived)
- CLK  in  1  clock, all state changes on rising edge
- RST  in  1  asynchronous, active-high reset
- START  in  1  command request; sampled only in IDLE
- LEN  in  LEN_W  number of MAC operations; latched on accepted START
- CH_SEL  in  CH_W  target accumulator channel; latched on accepted START
- MODE  in  1  0 = clear accumulator first, 1 = accumulate onto existing value; latched on accepted START
- ABORT  in  1  cancel the running command
- IN_VALID  in  1  operand pair present on datapath inputs
- IN_READY  out  1  sequencer will consume operands this cycle
- CLR  out  1  clear selected accumulator
- EN  out  1  perform one multiply-accumulate into selected accumulator
- ACC_SEL  out  CH_W  accumulator channel select (latched CH_SEL)
- OUT_LOAD  out  1  latch selected accumulator into output register
- BUSY  out  1  command in progress
- DONE  out  1  one-cycle completion pulse

## Operation
- States: IDLE, CLEAR, RUN, LOAD, DONE_S. The internal register holds the operation counter (LEN_W bits), the latched length, the channel and the mode.
- IDLE, START=1, LEN≠0, MODE=0: go to CLEAR.
- IDLE, START=1, LEN≠0, MODE=1: go to RUN.
- IDLE, START=1, LEN=0: go to DONE_S. No CLR, EN or OUT_LOAD is issued.
- CLEAR: CLR=1 for one cycle, then go to RUN. The counter is cleared on START acceptance.
- RUN: IN_READY=1. EN = IN_VALID (combinational, RUN only).
  - Each cycle with IN_VALID=1 increments the counter.
  - A beat with IN_VALID=1 and counter = latched LEN−1 is the last beat. The next state is LOAD.
  - IN_VALID=0 holds state and counter.
- LOAD: OUT_LOAD=1 for one cycle, then go to DONE_S.
- DONE_S: DONE=1 for one cycle, then go to IDLE.
- ABORT=1 in CLEAR or RUN returns to IDLE on the next edge.
  - No OUT_LOAD or DONE is issued.
  - An EN in the abort cycle is suppressed.
  - ABORT is ignored in IDLE, LOAD and DONE_S.
  - ABORT has priority over last-beat completion.
- START outside IDLE is ignored and not queued. START and ABORT together in IDLE: START is accepted.
- BUSY=1 in CLEAR, RUN and LOAD. BUSY=0 in IDLE and DONE_S.
- ACC_SEL stays stable from START acceptance until the return to IDLE. It holds its last value in IDLE.
- CH_SEL ≥ CH is saturated to CH−1 when latched.
- Reset state: IDLE, counter 0, latched LEN/CH/MODE = 0. All outputs are 0, including ACC_SEL=0.

## Timing
- START accepted at edge 0 with MODE=0, LEN=n, IN_VALID continuously 1:
  - CLR in cycle 1.
  - EN in cycles 2…n+1.
  - OUT_LOAD in cycle n+2.
  - DONE in cycle n+3.
  - IDLE from cycle n+4.
- With MODE=1 every step is one cycle earlier: EN in cycles 1…n, DONE in cycle n+2.
- With LEN=0: DONE in cycle 1, IDLE in cycle 2.
- Earliest back-to-back command: START is accepted in the first IDLE cycle after DONE.
- Every IN_VALID=0 cycle in RUN adds exactly one cycle of latency.
- RST assertion mid-command forces IDLE and all-zero outputs immediately, without waiting for CLK. No DONE is issued.
- The first rising CLK edge after RST deasserts is a normal IDLE cycle.

## Structure
- Shared package mac_pkg:
  - state encoding constants (3-bit: IDLE=000, CLEAR=001, RUN=010, LOAD=011, DONE_S=100)
  - MODE constants MODE_CLEAR=0, MODE_ACCUM=1
- Sub-module mac_op_counter (parameter LEN_W):
  - inputs: clear, increment enable, terminal value
  - outputs: count and last-beat flag
  - asynchronous reset on RST
- Next-state and output logic stay in mac_sequencer.

## Test plan
- Reset mid-RUN (LEN=5, after 2 beats) → all outputs 0 asynchronously, IDLE. A fresh START with LEN=3 then completes normally.
- MODE=0, LEN=4, CH_SEL=1, IN_VALID=1 throughout → CLR cycle 1; EN cycles 2–5; OUT_LOAD cycle 6; DONE cycle 7; ACC_SEL=1 throughout.
- MODE=1, LEN=3, IN_VALID pattern 1,0,1,0,1 → no CLR; exactly 3 EN pulses; OUT_LOAD the cycle after the third EN; DONE one cycle later.
- LEN=0 → no CLR, EN or OUT_LOAD; DONE in cycle 1; BUSY never 1.
- ABORT on the last beat (LEN=2) → no OUT_LOAD or DONE; EN suppressed on that beat; IDLE next cycle. START during RUN is ignored.
- LEN=15 (LEN_W=4) with CH_SEL=3 and CH=2 → 15 EN pulses with no counter wrap; ACC_SEL=1; DONE in cycle 18.
